// File: rtl/ppu_pixel_shifter_pkg.sv
// Shared PPU types and helpers for the background pixel shifter:
// line geometry, shifter state encoding and the palette lookup.
package ppu_pixel_shifter_pkg;

  localparam int SCREEN_WIDTH = 160;
  localparam int XW           = 8;

  typedef enum logic [1:0] {
    SHIFT_IDLE,
    SHIFT_DISCARD,
    SHIFT_PUSH,
    SHIFT_DONE
  } shifter_state_t;

  // Maps a 2-bit colour index to a shade through a BGP/OBP-style palette byte.
  function automatic logic [1:0] apply_palette(input logic [7:0] pal, input logic [1:0] idx);
    return pal[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/ppu_pixel_shifter_if.sv
// Shifter bus: line control and palette in, FIFO head/pop, framebuffer pixel
// stream out. The slave modport is the shifter; master is the PPU/FIFO side.
interface ppu_pixel_shifter_if;
  import ppu_pixel_shifter_pkg::*;

  logic          start_line;
  logic [2:0]    scx_fine;
  logic [7:0]    bgp;
  logic          bg_enable;
  logic          stall;
  logic          fifo_valid;
  logic [1:0]    fifo_pixel;
  logic          fifo_pop;
  logic          pix_valid;
  logic [1:0]    pix_color;
  logic [XW-1:0] pix_x;
  logic          line_done;
  logic          busy;

  modport slave (
    input  start_line, scx_fine, bgp, bg_enable, stall, fifo_valid, fifo_pixel,
    output fifo_pop, pix_valid, pix_color, pix_x, line_done, busy
  );

  modport master (
    output start_line, scx_fine, bgp, bg_enable, stall, fifo_valid, fifo_pixel,
    input  fifo_pop, pix_valid, pix_color, pix_x, line_done, busy
  );

endinterface

// File: rtl/ppu_pixel_shifter.sv
// Background pixel shifter: pops the fetcher FIFO during Mode 3, drops the
// SCX fine-scroll pixels, and streams palette-mapped pixels with X coordinate.
module ppu_pixel_shifter
  import ppu_pixel_shifter_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  ppu_pixel_shifter_if.slave  io
);

  shifter_state_t state_q, state_d;
  logic [XW-1:0]  x_q, x_d;
  logic [2:0]     discard_q, discard_d;
  logic           pix_valid_q, pix_valid_d;
  logic [1:0]     pix_color_q, pix_color_d;
  logic [XW-1:0]  pix_x_q, pix_x_d;
  logic           line_done_q, line_done_d;
  logic           pop, push, last;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    pop  = ((state_q == SHIFT_DISCARD) || (state_q == SHIFT_PUSH)) && io.fifo_valid && !io.stall;
    push = pop && (state_q == SHIFT_PUSH);
    last = push && (x_q == XW'(SCREEN_WIDTH - 1));

    state_d     = state_q;
    x_d         = x_q;
    discard_d   = discard_q;
    pix_valid_d = push;
    pix_color_d = pix_color_q;
    pix_x_d     = pix_x_q;
    line_done_d = 1'b0;

    // A pixel popped in the same cycle as a restart still emits with its old X.
    if (push) begin
      pix_color_d = io.bg_enable ? apply_palette(io.bgp, io.fifo_pixel) : 2'b00;
      pix_x_d     = x_q;
    end

    if (io.start_line) begin
      discard_d = io.scx_fine;
      x_d       = '0;
      state_d   = (io.scx_fine != 3'd0) ? SHIFT_DISCARD : SHIFT_PUSH;
    end else begin
      case (state_q)
        SHIFT_IDLE: ;
        SHIFT_DISCARD: begin
          if (pop) begin
            discard_d = discard_q - 3'd1;
            if (discard_q == 3'd1) state_d = SHIFT_PUSH;
          end
        end
        SHIFT_PUSH: begin
          if (last) begin
            state_d     = SHIFT_DONE;
            line_done_d = 1'b1;
          end else if (push) begin
            x_d = x_q + 1'b1;
          end
        end
        SHIFT_DONE: state_d = SHIFT_IDLE;
        default:    state_d = SHIFT_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SHIFT_IDLE;
      x_q         <= '0;
      discard_q   <= '0;
      pix_valid_q <= 1'b0;
      pix_color_q <= 2'b00;
      pix_x_q     <= '0;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      discard_q   <= discard_d;
      pix_valid_q <= pix_valid_d;
      pix_color_q <= pix_color_d;
      pix_x_q     <= pix_x_d;
      line_done_q <= line_done_d;
    end
  end

  assign io.fifo_pop  = pop;
  assign io.pix_valid = pix_valid_q;
  assign io.pix_color = pix_color_q;
  assign io.pix_x     = pix_x_q;
  assign io.line_done = line_done_q;
  assign io.busy      = (state_q != SHIFT_IDLE);

endmodule

// File: tb/tb_ppu_pixel_shifter.sv
// Self-checking bench for ppu_pixel_shifter: a hand-computed vector table,
// directed line scenarios and randomized lines against a pop-count line model.
module tb_ppu_pixel_shifter;
  import ppu_pixel_shifter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ppu_pixel_shifter_if io();
  ppu_pixel_shifter dut (.clk(clk), .reset(reset), .io(io));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stimulus applied by step()
  bit       t_start, t_bgen, t_stall, t_fv;
  int       t_scx, t_bgp, t_fpx;

  // Line model: a line is a run of pops; pop k drops if k < scx, else it is pixel x = k - scx.
  bit m_on, m_done;
  int m_pops, m_scx;
  bit e_pop, e_pv, e_done;
  int e_color, e_x;

  int  fifo_idx, pop_total, valid_total, done_total, done_x, first_color;
  bit  saw_done;

  function automatic int ref_shade(int pal, int idx, bit en);
    return en ? ((pal >> (2 * idx)) & 3) : 0;
  endfunction

  task automatic model_reset();
    m_on = 0; m_done = 0; m_pops = 0; m_scx = 0;
    e_pv = 0; e_done = 0; e_color = 0; e_x = 0;
  endtask

  task automatic clear_counts();
    fifo_idx = 0; pop_total = 0; valid_total = 0; done_total = 0;
    done_x = -1; first_color = -1; saw_done = 0;
  endtask

  task automatic step();
    bit pixel;
    int px;
    @(negedge clk);
    io.start_line = t_start;
    io.scx_fine   = 3'(t_scx);
    io.bgp        = 8'(t_bgp);
    io.bg_enable  = t_bgen;
    io.stall      = t_stall;
    io.fifo_valid = t_fv;
    io.fifo_pixel = 2'(t_fpx);
    #1;
    e_pop = m_on && t_fv && !t_stall;
    check("fifo_pop", io.fifo_pop, e_pop);
    if (io.fifo_pop) pop_total++;
    @(posedge clk);
    pixel = e_pop && (m_pops >= m_scx);
    px    = m_pops - m_scx;
    e_pv  = pixel;
    if (pixel) begin
      e_x     = px;
      e_color = ref_shade(t_bgp, t_fpx, t_bgen);
    end
    e_done = pixel && (px == SCREEN_WIDTH - 1) && !t_start;
    if (t_start) begin
      m_on = 1; m_done = 0; m_pops = 0; m_scx = t_scx;
    end else if (m_done) begin
      m_done = 0;
    end else if (e_pop) begin
      m_pops++;
      if (pixel && px == SCREEN_WIDTH - 1) begin
        m_on = 0; m_done = 1;
      end
    end
    if (e_pop) fifo_idx++;
    #1;
    check("pix_valid", io.pix_valid, e_pv);
    check("line_done", io.line_done, e_done);
    check("busy", io.busy, m_on || m_done);
    if (e_pv) begin
      check("pix_x", io.pix_x, e_x);
      check("pix_color", io.pix_color, e_color);
    end
    if (io.pix_valid) begin
      if (valid_total == 0) first_color = io.pix_color;
      valid_total++;
    end
    if (io.line_done) begin
      done_total++;
      done_x   = io.pix_x;
      saw_done = 1;
    end
  endtask

  task automatic start_line(input int scx);
    t_start = 1; t_scx = scx; t_fv = 1; t_stall = 0; t_fpx = fifo_idx % 4;
    step();
    t_start = 0;
  endtask

  // mode 0: steady FIFO; 1: valid gap at x=40, stall at x=80; 2: random; 3: bg off from x=80
  task automatic run_to_done(input string tag, input int mode, input int budget);
    int gap_fv = 0, gap_st = 0;
    saw_done = 0;
    for (int c = 0; c < budget && !saw_done; c++) begin
      t_start = 0; t_fv = 1; t_stall = 0; t_fpx = fifo_idx % 4;
      if (mode == 1) begin
        if (m_pops >= 40 && gap_fv < 3) begin t_fv = 0; gap_fv++; end
        else if (m_pops >= 80 && gap_st < 2) begin t_stall = 1; gap_st++; end
      end else if (mode == 2) begin
        t_fv    = ($urandom_range(0, 3) != 0);
        t_stall = ($urandom_range(0, 4) == 0);
        t_fpx   = $urandom_range(0, 3);
        t_bgen  = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 15) == 0) t_bgp = $urandom_range(0, 255);
        if ($urandom_range(0, 399) == 0) begin t_start = 1; t_scx = $urandom_range(0, 7); end
      end else if (mode == 3) begin
        if (m_pops >= 80) t_bgen = 0;
      end
      step();
    end
    check({tag, "_done_seen"}, saw_done, 1);
  endtask

  task automatic idle_cycles(input int n);
    t_start = 0; t_fv = 0; t_stall = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    bit start; int scx; int bgp; bit bgen; bit stall; bit fv; int fpx;
    bit e_pop; bit e_pv; int e_col; int e_x; bit e_done; bit e_busy;
  } vec_t;
  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1, 2, 8'hE4, 1, 0, 1, 3,  0, 0, 0, 0, 0, 1};
    tbl[1]  = '{0, 0, 8'hE4, 1, 0, 1, 1,  1, 0, 0, 0, 0, 1};
    tbl[2]  = '{0, 0, 8'hE4, 1, 0, 1, 2,  1, 0, 0, 0, 0, 1};
    tbl[3]  = '{0, 0, 8'hE4, 1, 0, 1, 2,  1, 1, 2, 0, 0, 1};
    tbl[4]  = '{0, 0, 8'hE4, 1, 0, 0, 3,  0, 0, 0, 0, 0, 1};
    tbl[5]  = '{0, 0, 8'hE4, 1, 1, 1, 3,  0, 0, 0, 0, 0, 1};
    tbl[6]  = '{0, 0, 8'hE4, 1, 0, 1, 3,  1, 1, 3, 1, 0, 1};
    tbl[7]  = '{0, 0, 8'h1B, 1, 0, 1, 1,  1, 1, 2, 2, 0, 1};
    tbl[8]  = '{0, 0, 8'h1B, 0, 0, 1, 1,  1, 1, 0, 3, 0, 1};
    tbl[9]  = '{1, 0, 8'hE4, 1, 0, 1, 0,  1, 1, 0, 4, 0, 1};
    tbl[10] = '{0, 0, 8'hE4, 1, 0, 1, 3,  1, 1, 3, 0, 0, 1};
    tbl[11] = '{0, 0, 8'hE4, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1};

    reset = 1'b0;
    io.start_line = 0; io.scx_fine = 0; io.bgp = 8'hE4; io.bg_enable = 1;
    io.stall = 0; io.fifo_valid = 1; io.fifo_pixel = 0;
    t_start = 0; t_scx = 0; t_bgp = 8'hE4; t_bgen = 1; t_stall = 0; t_fv = 0; t_fpx = 0;
    model_reset();
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check("rst_pix_valid", io.pix_valid, 0);
    check("rst_pix_color", io.pix_color, 0);
    check("rst_pix_x", io.pix_x, 0);
    check("rst_line_done", io.line_done, 0);
    check("rst_busy", io.busy, 0);
    check("rst_fifo_pop", io.fifo_pop, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      io.start_line = tbl[i].start;
      io.scx_fine   = 3'(tbl[i].scx);
      io.bgp        = 8'(tbl[i].bgp);
      io.bg_enable  = tbl[i].bgen;
      io.stall      = tbl[i].stall;
      io.fifo_valid = tbl[i].fv;
      io.fifo_pixel = 2'(tbl[i].fpx);
      #1;
      check($sformatf("tbl%0d_pop", i), io.fifo_pop, tbl[i].e_pop);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_pix_valid", i), io.pix_valid, tbl[i].e_pv);
      check($sformatf("tbl%0d_line_done", i), io.line_done, tbl[i].e_done);
      check($sformatf("tbl%0d_busy", i), io.busy, tbl[i].e_busy);
      if (tbl[i].e_pv) begin
        check($sformatf("tbl%0d_pix_color", i), io.pix_color, tbl[i].e_col);
        check($sformatf("tbl%0d_pix_x", i), io.pix_x, tbl[i].e_x);
      end
    end

    // Mid-cycle async reset clears the table's half-finished line.
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("tbl_reset_busy", io.busy, 0);
    check("tbl_reset_pix_valid", io.pix_valid, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // 1: no scroll, steady FIFO
    t_bgp = 8'hE4; t_bgen = 1;
    clear_counts();
    start_line(0);
    run_to_done("t1", 0, 300);
    check("t1_pops", pop_total, 160);
    check("t1_pixels", valid_total, 160);
    check("t1_line_done_count", done_total, 1);
    check("t1_done_x", done_x, 159);
    idle_cycles(2);

    // 2: fine scroll of 5
    clear_counts();
    start_line(5);
    run_to_done("t2", 0, 300);
    check("t2_pops", pop_total, 165);
    check("t2_pixels", valid_total, 160);
    check("t2_first_color", first_color, 1);
    idle_cycles(2);

    // 3: inverted palette, background disabled from x=80
    t_bgp = 8'h1B; t_bgen = 1;
    clear_counts();
    start_line(0);
    run_to_done("t3", 3, 300);
    check("t3_first_color", first_color, 3);
    check("t3_pixels", valid_total, 160);
    t_bgp = 8'hE4; t_bgen = 1;
    idle_cycles(2);

    // 4: FIFO empty gap then stall gap
    clear_counts();
    start_line(0);
    run_to_done("t4", 1, 300);
    check("t4_pops", pop_total, 160);
    check("t4_pixels", valid_total, 160);
    check("t4_line_done_count", done_total, 1);
    idle_cycles(2);

    // 5: restart at x=100 with scx=2
    clear_counts();
    start_line(0);
    for (int c = 0; c < 200 && m_pops < 100; c++) begin
      t_fv = 1; t_stall = 0; t_fpx = fifo_idx % 4;
      step();
    end
    start_line(2);
    check("t5_no_done_before_restart", done_total, 0);
    pop_total = 0; valid_total = 0; done_total = 0;
    run_to_done("t5", 0, 300);
    check("t5_pops", pop_total, 162);
    check("t5_pixels", valid_total, 160);
    check("t5_line_done_count", done_total, 1);
    idle_cycles(2);

    // 6: async reset at x=50
    clear_counts();
    start_line(0);
    for (int c = 0; c < 200 && m_pops < 50; c++) begin
      t_fv = 1; t_stall = 0; t_fpx = fifo_idx % 4;
      step();
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t6_pix_valid", io.pix_valid, 0);
    check("t6_pix_color", io.pix_color, 0);
    check("t6_pix_x", io.pix_x, 0);
    check("t6_line_done", io.line_done, 0);
    check("t6_busy", io.busy, 0);
    check("t6_fifo_pop", io.fifo_pop, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_counts();
    start_line(0);
    run_to_done("t6", 0, 300);
    check("t6_pixels", valid_total, 160);
    check("t6_done_x", done_x, 159);
    idle_cycles(2);

    // Randomized lines
    for (int l = 0; l < 6; l++) begin
      t_bgp = $urandom_range(0, 255);
      clear_counts();
      start_line($urandom_range(0, 7));
      run_to_done($sformatf("rand%0d", l), 2, 3000);
      idle_cycles($urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
